// File: rtl/uart_rx_fsm.sv
// uart_rx_fsm -- UART 8N1 receiver, the link-side peer of tx_fsm.
//
// The RX line is brought into the clk domain through a two-flop
// synchroniser. The start bit is qualified at mid-bit. Each data bit
// and the stop bit are then sampled one full bit period apart, which
// places every sample at the centre of its bit.
//
// Handshake: valid is a one-cycle strobe. No ready is involved; the
// consumer must take data_out in the cycle valid is high. data_out
// holds the last correctly framed byte until the next valid strobe.
// frame_err is a one-cycle strobe that marks a discarded byte. It is
// never high in the same cycle as valid.
//
// Ports
//   clk        in   1  system clock, rising edge
//   RSTn       in   1  asynchronous reset, active-low
//   RX         in   1  serial line, idle high, asynchronous to clk
//   data_out   out  8  last correctly framed byte, LSB received first
//   valid      out  1  one-cycle pulse: data_out updated this cycle
//   frame_err  out  1  one-cycle pulse: stop bit sampled low, byte dropped
//   busy       out  1  high whenever the FSM is not in IDLE
//   state_dbg  out  3  current FSM state, for checkers and debug
module uart_rx_fsm #(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic       clk,
  input  logic       RSTn,
  input  logic       RX,
  output logic [7:0] data_out,
  output logic       valid,
  output logic       frame_err,
  output logic       busy,
  output logic [2:0] state_dbg
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int H  = (CLKS_PER_BIT - 1) / 2;
  // The counter register lags the edge count by one. When it holds H-1,
  // this edge is the H-th edge after entering START, which is mid-bit.
  localparam logic [CW-1:0] START_LAST = CW'(H - 1);
  localparam logic [CW-1:0] BIT_LAST   = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BRK   = 3'd4
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    idx, idx_n;
  logic [7:0]    shreg, shreg_n;
  logic [7:0]    data_n;
  logic          valid_n, ferr_n;
  logic          sync1, rx_s;

  // The synchroniser resets to 1 (idle line), so a reset release
  // cannot look like a start edge.
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= RX;
      rx_s  <= sync1;
    end
  end

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      shreg     <= '0;
      data_out  <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      idx       <= idx_n;
      shreg     <= shreg_n;
      data_out  <= data_n;
      valid     <= valid_n;
      frame_err <= ferr_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    shreg_n = shreg;
    data_n  = data_out;
    valid_n = 1'b0;
    ferr_n  = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_n = START;
          cnt_n   = '0;
        end
      end
      START: begin
        if (cnt == START_LAST) begin
          cnt_n = '0;
          idx_n = '0;
          // A line that is high again at mid-bit was a glitch.
          // Return to IDLE quietly in that case.
          state_n = rx_s ? IDLE : DATA;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_n        = '0;
          shreg_n[idx] = rx_s;
          if (idx == 3'd7) begin
            state_n = STOP;
          end else begin
            idx_n = idx + 3'd1;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_n = '0;
          if (rx_s) begin
            data_n  = shreg;
            valid_n = 1'b1;
            state_n = IDLE;
          end else begin
            ferr_n  = 1'b1;
            state_n = BRK;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      BRK: begin
        // Wait for the line to go high again. Without this state, a
        // held-low line (break) would start a stream of bogus frames.
        if (rx_s) state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  assign busy      = (state != IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_uart_rx_fsm.sv
module tb_uart_rx_fsm;

  localparam int CPB = 10;

  logic       clk;
  logic       RSTn;
  logic       RX;
  logic [7:0] data_out;
  logic       valid;
  logic       frame_err;
  logic       busy;
  logic [2:0] state_dbg;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int c0;
  int t_high;

  // Event logs filled by the monitor (cycle stamps taken on negedge).
  int         v_cyc[$];
  logic [7:0] v_dat[$];
  int         fe_cyc[$];
  int         bf_cyc[$];
  int         both_hi = 0;
  logic       busy_prev = 1'b0;

  uart_rx_fsm #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .RSTn      (RSTn),
    .RX        (RX),
    .data_out  (data_out),
    .valid     (valid),
    .frame_err (frame_err),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // Clock and reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: log strobes and busy falling edges away from the active edge.
  always @(negedge clk) begin
    if (valid) begin
      v_cyc.push_back(cyc);
      v_dat.push_back(data_out);
    end
    if (frame_err) fe_cyc.push_back(cyc);
    if (valid && frame_err) both_hi = both_hi + 1;
    if (busy_prev && !busy) bf_cyc.push_back(cyc);
    busy_prev = busy;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    v_cyc.delete();
    v_dat.delete();
    fe_cyc.delete();
    bf_cyc.delete();
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Driver: one bit per CPB clocks. It must be called at #1 after a
  // posedge and it returns at #1 after a posedge.
  task automatic send_bit(input logic b);
    RX = b;
    step(CPB);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop_bit);
  endtask

  initial begin
    RX   = 1'b1;
    RSTn = 1'b0;

    // Reset
    step(4);
    @(negedge clk);
    chk("rst_data", {24'd0, data_out}, 32'h00);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_ferr", {31'd0, frame_err}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_state", {29'd0, state_dbg}, 32'd0);
    @(posedge clk); #1;
    RSTn = 1'b1;
    step(5);

    // Frame 0x55: stop sampled at edge 96 -> valid/busy-fall seen at c0+97
    clear_logs();
    c0 = cyc;
    send_frame(8'h55, 1'b1);
    step(5);
    chk("f55_nvalid", v_cyc.size(), 32'd1);
    chk("f55_vcyc", (v_cyc.size() > 0) ? v_cyc[0] - c0 : -1, 32'd97);
    chk("f55_vdat", (v_dat.size() > 0) ? {24'd0, v_dat[0]} : 32'hFFFF, 32'h55);
    chk("f55_bfall", (bf_cyc.size() > 0) ? bf_cyc[0] - c0 : -1, 32'd97);
    chk("f55_nferr", fe_cyc.size(), 32'd0);
    chk("f55_data", {24'd0, data_out}, 32'h55);

    // Back-to-back 0xA5, 0x3C with no idle gap
    clear_logs();
    c0 = cyc;
    send_frame(8'hA5, 1'b1);
    send_frame(8'h3C, 1'b1);
    step(5);
    chk("b2b_nvalid", v_cyc.size(), 32'd2);
    chk("b2b_first", (v_cyc.size() > 0) ? v_cyc[0] - c0 : -1, 32'd97);
    chk("b2b_gap", (v_cyc.size() > 1) ? v_cyc[1] - v_cyc[0] : -1, 32'd100);
    chk("b2b_dat0", (v_dat.size() > 0) ? {24'd0, v_dat[0]} : 32'hFFFF, 32'hA5);
    chk("b2b_dat1", (v_dat.size() > 1) ? {24'd0, v_dat[1]} : 32'hFFFF, 32'h3C);

    // Glitch: low 3 cycles. START is entered at edge 2 and rejected at edge 6.
    clear_logs();
    c0 = cyc;
    RX = 1'b0;
    step(3);
    RX = 1'b1;
    step(12);
    chk("gl_nvalid", v_cyc.size(), 32'd0);
    chk("gl_bfall", (bf_cyc.size() > 0) ? bf_cyc[0] - c0 : -1, 32'd7);
    chk("gl_state", {29'd0, state_dbg}, 32'd0);
    chk("gl_data", {24'd0, data_out}, 32'h3C);

    // Framing error: 0xF0 with a low stop bit, then the line is held low
    // for 30 more cycles. RX returns high at c0+130, rx_s at edge 131,
    // and BREAK exits at edge 132.
    clear_logs();
    c0 = cyc;
    send_frame(8'hF0, 1'b0);
    step(30);
    chk("fe_busy_held", {31'd0, busy}, 32'd1);
    t_high = cyc - c0;
    RX = 1'b1;
    step(15);
    chk("fe_thigh", t_high, 32'd130);
    chk("fe_nferr", fe_cyc.size(), 32'd1);
    chk("fe_cyc", (fe_cyc.size() > 0) ? fe_cyc[0] - c0 : -1, 32'd97);
    chk("fe_nvalid", v_cyc.size(), 32'd0);
    chk("fe_data", {24'd0, data_out}, 32'h3C);
    chk("fe_nbfall", bf_cyc.size(), 32'd1);
    chk("fe_bfall", (bf_cyc.size() > 0) ? bf_cyc[0] - c0 : -1, 32'd133);
    chk("fe_state", {29'd0, state_dbg}, 32'd0);

    // Reset mid-frame during bit 3 of 0x81, then send 0x42
    clear_logs();
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    RX = 1'b0;
    step(5);
    chk("mr_busy_pre", {31'd0, busy}, 32'd1);
    RSTn = 1'b0;
    #1;
    chk("mr_busy_rst", {31'd0, busy}, 32'd0);
    chk("mr_data_rst", {24'd0, data_out}, 32'h00);
    step(3);
    RX = 1'b1;
    step(1);
    RSTn = 1'b1;
    step(12);
    chk("mr_nostrobe", v_cyc.size() + fe_cyc.size(), 32'd0);
    send_frame(8'h42, 1'b1);
    step(5);
    chk("mr_nvalid", v_cyc.size(), 32'd1);
    chk("mr_vdat", (v_dat.size() > 0) ? {24'd0, v_dat[0]} : 32'hFFFF, 32'h42);
    chk("mr_nferr", fe_cyc.size(), 32'd0);

    // Serialiser in tx_fsm format standing in for a TX->RX loopback: 0x55, 0xC3
    clear_logs();
    send_frame(8'h55, 1'b1);
    step(7);
    send_frame(8'hC3, 1'b1);
    step(5);
    chk("lb_nvalid", v_cyc.size(), 32'd2);
    chk("lb_dat0", (v_dat.size() > 0) ? {24'd0, v_dat[0]} : 32'hFFFF, 32'h55);
    chk("lb_dat1", (v_dat.size() > 1) ? {24'd0, v_dat[1]} : 32'hFFFF, 32'hC3);
    chk("lb_data", {24'd0, data_out}, 32'hC3);

    chk("excl_strobes", both_hi, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
